// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller.
//   - dm_op_e    : request operation encodings (loads 0..4, stores 5..7)
//   - dm_state_e : controller FSM states
//   - defaults for the legal address limit and the address exception codes
//   - is_store() : classifies an operation as a store
package dm_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } dm_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

    localparam logic [31:0] DM_LIMIT_DEF = 32'h0000_2fff;
    localparam logic [4:0]  EXC_ADEL_DEF = 5'd4;
    localparam logic [4:0]  EXC_ADES_DEF = 5'd5;

    function automatic logic is_store(input dm_op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Bus bundle between the memory stage, the controller and the data memory.
//   req_*  : request handshake (valid/ready) with op, byte address, store data, PC
//   dm_*   : data-memory port (address, write data, byte enables, trace PC, read word)
//   resp_* : response handshake (valid/ready) with load data and exception info
// Modports: slave = the controller's view, master = the environment's view.
interface dm_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic [31:0] dm_A;
    logic [31:0] dm_WD;
    logic [3:0]  dm_BE;
    logic [31:0] dm_PC;
    logic [31:0] dm_rdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [4:0]  resp_exccode;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata, resp_ready,
        output req_ready, dm_A, dm_WD, dm_BE, dm_PC,
               resp_valid, resp_rdata, resp_exc, resp_exccode
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata, resp_ready,
        input  req_ready, dm_A, dm_WD, dm_BE, dm_PC,
               resp_valid, resp_rdata, resp_exc, resp_exccode
    );

endinterface

// File: rtl/dm_load_ext.sv
// Load data extraction: picks the byte/half lane of the memory word selected
// by the low address bits and sign- or zero-extends it.
//   op      : load operation (store ops yield 0)
//   addr_lo : byte address bits [1:0]
//   word    : aligned memory read word
//   data    : extended load result
module dm_load_ext
    import dm_pkg::*;
(
    input  dm_op_e      op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        b_sel = word[{addr_lo, 3'b000} +: 8];
        h_sel = addr_lo[1] ? word[31:16] : word[15:0];
        data  = 32'h0;
        case (op)
            OP_LW:   data = word;
            OP_LH:   data = {{16{h_sel[15]}}, h_sel};
            OP_LHU:  data = {16'h0, h_sel};
            OP_LB:   data = {{24{b_sel[7]}}, b_sel};
            OP_LBU:  data = {24'h0, b_sel};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: accepts one load/store per request
// handshake, performs a single-cycle memory access, and returns extended
// load data or an address exception through the response handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dm_access_ctrl_if.slave (request, memory port, response)
// Bad addresses (above DM_LIMIT or misaligned) skip the access entirely and
// go straight to the response with ADEL (loads) or ADES (stores).
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEF,
    parameter logic [4:0]  EXC_ADEL = EXC_ADEL_DEF,
    parameter logic [4:0]  EXC_ADES = EXC_ADES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    dm_access_ctrl_if.slave   bus
);

    dm_state_e   state;
    dm_op_e      cap_op;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] cap_pc;
    logic [3:0]  be_q;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [4:0]  resp_exccode;

    dm_op_e      req_op;
    logic        misaligned;
    logic        addr_bad;
    logic [3:0]  be_next;
    logic [31:0] ext_data;

    assign req_op = dm_op_e'(bus.req_op);

    // Address legality of the incoming request.
    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         misaligned = |bus.req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned = bus.req_addr[0];
            default:              misaligned = 1'b0;
        endcase
        addr_bad = (bus.req_addr > DM_LIMIT) || misaligned;
    end

    // Byte enables for the upcoming ACCESS cycle; loads never enable lanes.
    always_comb begin
        be_next = 4'b0000;
        case (req_op)
            OP_SW:   be_next = 4'b1111;
            OP_SH:   be_next = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            OP_SB:   be_next = 4'b0001 << bus.req_addr[1:0];
            default: be_next = 4'b0000;
        endcase
    end

    dm_load_ext u_load_ext (
        .op      (cap_op),
        .addr_lo (cap_addr[1:0]),
        .word    (bus.dm_rdata),
        .data    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cap_op       <= OP_LW;
            cap_addr     <= 32'h0;
            cap_wdata    <= 32'h0;
            cap_pc       <= 32'h0;
            be_q         <= 4'b0000;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_exc     <= 1'b0;
            resp_exccode <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is exactly "IDLE and not in reset" here.
                    if (bus.req_valid) begin
                        cap_op    <= req_op;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        cap_pc    <= bus.req_pc;
                        if (addr_bad) begin
                            state        <= RESP;
                            resp_valid   <= 1'b1;
                            resp_rdata   <= 32'h0;
                            resp_exc     <= 1'b1;
                            resp_exccode <= is_store(req_op) ? EXC_ADES : EXC_ADEL;
                        end else begin
                            state <= ACCESS;
                            be_q  <= be_next;
                        end
                    end
                end
                ACCESS: begin
                    // Store commits and load sample both happen at this edge.
                    state        <= RESP;
                    be_q         <= 4'b0000;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= is_store(cap_op) ? 32'h0 : ext_data;
                    resp_exc     <= 1'b0;
                    resp_exccode <= 5'd0;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == IDLE) && !reset;
    assign bus.dm_A         = cap_addr;
    assign bus.dm_WD        = cap_wdata;
    // The memory trace subtracts 4, so hand it pc+4 to print the real PC.
    assign bus.dm_PC        = cap_pc + 32'd4;
    // Gate with reset so an access interrupted by reset never writes.
    assign bus.dm_BE        = reset ? 4'b0000 : be_q;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_rdata   = resp_rdata;
    assign bus.resp_exc     = resp_exc;
    assign bus.resp_exccode = resp_exccode;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: behavioural byte-lane memory,
// a table of directed transactions, plus a hand sequence for reset mid-access.
module tb_dm_access_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dm_access_ctrl_if bus ();

    dm_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: combinational read, byte-lane write; the memory places the
    // low byte/half of dm_WD into the enabled lane(s).
    logic [31:0] mem [0:4095];
    assign bus.dm_rdata = mem[bus.dm_A[13:2]];

    always @(posedge clk) begin
        case (bus.dm_BE)
            4'b1111: mem[bus.dm_A[13:2]]        <= bus.dm_WD;
            4'b0011: mem[bus.dm_A[13:2]][15:0]  <= bus.dm_WD[15:0];
            4'b1100: mem[bus.dm_A[13:2]][31:16] <= bus.dm_WD[15:0];
            4'b0001: mem[bus.dm_A[13:2]][7:0]   <= bus.dm_WD[7:0];
            4'b0010: mem[bus.dm_A[13:2]][15:8]  <= bus.dm_WD[7:0];
            4'b0100: mem[bus.dm_A[13:2]][23:16] <= bus.dm_WD[7:0];
            4'b1000: mem[bus.dm_A[13:2]][31:24] <= bus.dm_WD[7:0];
            default: ;
        endcase
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] rdata;
        logic        exc;
        logic [4:0]  code;
        logic [3:0]  be;
    } vec_t;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold,
                                input logic [31:0] rdata, input logic exc,
                                input logic [4:0] code, input logic [3:0] be);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.hold = hold;
        v.rdata = rdata; v.exc = exc; v.code = code; v.be = be;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input logic [31:0] pc);
        int          cyc;
        int          be_cnt;
        bit          got;
        bit          is_st;
        logic [3:0]  be_seen;
        logic [31:0] a_seen, wd_seen, pc_seen;
        is_st   = (v.op >= SW);
        be_cnt  = 0;
        be_seen = 4'b0000;
        a_seen  = 32'h0; wd_seen = 32'h0; pc_seen = 32'h0;
        @(negedge clk);
        chk("req_ready_idle", {31'h0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_pc    = pc;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus.dm_BE != 4'b0000) begin
                be_cnt++;
                be_seen = bus.dm_BE;
                a_seen  = bus.dm_A;
                wd_seen = bus.dm_WD;
                pc_seen = bus.dm_PC;
            end
            if (bus.resp_valid) got = 1'b1;
        end
        if (!got) begin
            chk("resp_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc, v.exc ? 32'd1 : 32'd2);
            chk("resp_rdata", bus.resp_rdata, v.rdata);
            chk("resp_exc", {31'h0, bus.resp_exc}, {31'h0, v.exc});
            chk("resp_exccode", {27'h0, bus.resp_exccode}, {27'h0, v.code});
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (bus.dm_BE != 4'b0000) be_cnt++;
                chk("hold_valid", {31'h0, bus.resp_valid}, 32'd1);
                chk("hold_rdata", bus.resp_rdata, v.rdata);
                chk("hold_req_ready", {31'h0, bus.req_ready}, 32'd0);
            end
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
            @(negedge clk);
            chk("post_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        end
        chk("be_count", be_cnt, (is_st && !v.exc) ? 32'd1 : 32'd0);
        chk("be_value", {28'h0, be_seen}, {28'h0, v.be});
        if (v.be != 4'b0000) begin
            chk("dm_A", a_seen, v.addr);
            chk("dm_WD", wd_seen, v.wdata);
            chk("dm_PC", pc_seen, pc + 32'd4);
        end
    endtask

    vec_t vecs [18];

    initial begin
        vecs[0]  = mk(SW,  32'h0000_0010, 32'h1234_5678, 0, 32'h0,          0, 5'd0, 4'b1111);
        vecs[1]  = mk(LW,  32'h0000_0010, 32'h0,         0, 32'h1234_5678,  0, 5'd0, 4'b0000);
        vecs[2]  = mk(LB,  32'h0000_0023, 32'h0,         0, 32'hFFFF_FF80,  0, 5'd0, 4'b0000);
        vecs[3]  = mk(LBU, 32'h0000_0023, 32'h0,         0, 32'h0000_0080,  0, 5'd0, 4'b0000);
        vecs[4]  = mk(LH,  32'h0000_0020, 32'h0,         0, 32'h0000_7F01,  0, 5'd0, 4'b0000);
        vecs[5]  = mk(LHU, 32'h0000_0022, 32'h0,         0, 32'h0000_80FF,  0, 5'd0, 4'b0000);
        vecs[6]  = mk(LB,  32'h0000_0021, 32'h0,         0, 32'h0000_007F,  0, 5'd0, 4'b0000);
        vecs[7]  = mk(LH,  32'h0000_0022, 32'h0,         0, 32'hFFFF_80FF,  0, 5'd0, 4'b0000);
        vecs[8]  = mk(SH,  32'h0000_0032, 32'h0000_BEEF, 0, 32'h0,          0, 5'd0, 4'b1100);
        vecs[9]  = mk(LW,  32'h0000_0030, 32'h0,         0, 32'hBEEF_2222,  0, 5'd0, 4'b0000);
        vecs[10] = mk(LW,  32'h0000_0006, 32'h0,         0, 32'h0,          1, 5'd4, 4'b0000);
        vecs[11] = mk(SB,  32'h0000_3000, 32'h0000_00CC, 0, 32'h0,          1, 5'd5, 4'b0000);
        vecs[12] = mk(SH,  32'h0000_0031, 32'h0000_1234, 0, 32'h0,          1, 5'd5, 4'b0000);
        vecs[13] = mk(SB,  32'h0000_0041, 32'h0000_00AB, 5, 32'h0,          0, 5'd0, 4'b0010);
        vecs[14] = mk(LW,  32'h0000_0040, 32'h0,         0, 32'h0000_AB00,  0, 5'd0, 4'b0000);
        vecs[15] = mk(LW,  32'h0000_2FFC, 32'h0,         0, 32'h0000_0000,  0, 5'd0, 4'b0000);
        vecs[16] = mk(LBU, 32'h0000_2FFF, 32'h0,         0, 32'h0000_0000,  0, 5'd0, 4'b0000);
        vecs[17] = mk(LW,  32'h0000_3000, 32'h0,         0, 32'h0,          1, 5'd4, 4'b0000);

        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[8]  = 32'h80FF_7F01;   // 0x20
        mem[12] = 32'h1111_2222;   // 0x30
        mem[20] = 32'hAAAA_AAAA;   // 0x50

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_pc     = 32'h0;
        bus.resp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd0);
        chk("rst_dm_BE", {28'h0, bus.dm_BE}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_exc", {31'h0, bus.resp_exc}, 32'd0);
        chk("rst_resp_exccode", {27'h0, bus.resp_exccode}, 32'd0);
        chk("rst_dm_A", bus.dm_A, 32'h0);
        chk("rst_dm_PC", bus.dm_PC, 32'h4);
        chk("rst_req_ready_after", {31'h0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 18; i++)
            do_txn(vecs[i], 32'h0040_0000 + 32'(i) * 32'd4);

        // Rejected store at 0x3000 must not have touched memory.
        chk("no_write_3000", mem[12'hC00], 32'h0);

        // Reset asserted during the ACCESS cycle of SW 0x50.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = SW;
        bus.req_addr  = 32'h0000_0050;
        bus.req_wdata = 32'h5555_5555;
        bus.req_pc    = 32'h0040_1000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_access_be", {28'h0, bus.dm_BE}, 32'hF);
        reset = 1'b1;
        #1;
        chk("mid_reset_be", {28'h0, bus.dm_BE}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("mid_reset_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        chk("mid_reset_no_write", mem[20], 32'hAAAA_AAAA);
        repeat (3) begin
            @(negedge clk);
            chk("mid_reset_quiet_valid", {31'h0, bus.resp_valid}, 32'd0);
            chk("mid_reset_quiet_be", {28'h0, bus.dm_BE}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
